// File: rtl/victim_cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : victim_cache_ctrl
//  Purpose  : L1 miss-path sequencer for a small fully associative victim
//             cache. Keeps the victim metadata (valid, dirty, tag) and the FIFO
//             replacement pointer. Line data lives in an external array that
//             is reached through vc_idx_o / vc_we_o. Each L1 miss probes the
//             victim entries. A hit swaps the line with the L1. A miss can
//             write back a dirty victim and then fetches the line from memory.
//  Options  : define VICTIM_CACHE_PERF_EN to add saturating hit, miss and
//             write-back counters.
//  Revision : 1.0  initial release
// ============================================================================
module victim_cache_ctrl #(
   parameter int LINE_WIDTH = 128,
   parameter int TAG_WIDTH  = 26,
   parameter int VC_ENTRIES = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          miss_req_i,
   input  logic [TAG_WIDTH-1:0]          miss_tag_i,
   input  logic                          evict_valid_i,
   input  logic                          evict_dirty_i,
   input  logic [TAG_WIDTH-1:0]          evict_tag_i,
   input  logic [LINE_WIDTH-1:0]         evict_data_i,
   output logic                          refill_valid_o,
   output logic [LINE_WIDTH-1:0]         refill_data_o,
   output logic                          refill_dirty_o,
   output logic                          miss_done_o,
   output logic [$clog2(VC_ENTRIES)-1:0] vc_idx_o,
   output logic                          vc_we_o,
   output logic [LINE_WIDTH-1:0]         vc_wdata_o,
   input  logic [LINE_WIDTH-1:0]         vc_rdata_i,
   output logic                          mem_wr_req_o,
   output logic [TAG_WIDTH-1:0]          mem_wr_tag_o,
   output logic [LINE_WIDTH-1:0]         mem_wr_data_o,
   input  logic                          mem_wr_ack_i,
   output logic                          mem_rd_req_o,
   output logic [TAG_WIDTH-1:0]          mem_rd_tag_o,
   input  logic                          mem_rd_valid_i,
   input  logic [LINE_WIDTH-1:0]         mem_rd_data_i
`ifdef VICTIM_CACHE_PERF_EN
  ,output logic [31:0]                   perf_hit_cnt_o,
   output logic [31:0]                   perf_miss_cnt_o,
   output logic [31:0]                   perf_wb_cnt_o
`endif
);

   localparam int IDX_W = $clog2(VC_ENTRIES);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PROBE = 3'd1,
      S_SWAP  = 3'd2,
      S_WB    = 3'd3,
      S_FILL  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t                 state_q, state_d;
   logic [VC_ENTRIES-1:0]  valid_q;
   logic [VC_ENTRIES-1:0]  dirty_q;
   logic [TAG_WIDTH-1:0]   tag_q [VC_ENTRIES];
   logic [IDX_W-1:0]       ptr_q;
   logic [IDX_W-1:0]       hit_idx_q;

   logic [VC_ENTRIES-1:0]  match;
   logic                   hit_any;
   logic [IDX_W-1:0]       hit_idx;

   // Only valid entries may take part in the tag match.
   for (genvar i = 0; i < VC_ENTRIES; i++) begin : g_cmp
      assign match[i] = valid_q[i] && (tag_q[i] == miss_tag_i);
   end

   // Pick the lowest matching index in case corrupted metadata matches twice.
   always_comb begin
      hit_any = |match;
      hit_idx = '0;
      for (int i = VC_ENTRIES - 1; i >= 0; i--) begin
         if (match[i]) hit_idx = IDX_W'(i);
      end
   end

   // State register. Reset aborts any sequence in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next-state and output decode. All outputs are quiet outside their phase.
   always_comb begin
      state_d        = state_q;
      refill_valid_o = 1'b0;
      refill_data_o  = '0;
      refill_dirty_o = 1'b0;
      miss_done_o    = 1'b0;
      vc_idx_o       = '0;
      vc_we_o        = 1'b0;
      vc_wdata_o     = '0;
      mem_wr_req_o   = 1'b0;
      mem_wr_tag_o   = '0;
      mem_wr_data_o  = '0;
      mem_rd_req_o   = 1'b0;
      mem_rd_tag_o   = '0;
      case (state_q)
         S_IDLE: begin
            if (miss_req_i) state_d = S_PROBE;
         end
         S_PROBE: begin
            vc_idx_o = ptr_q;
            if (hit_any)
               state_d = S_SWAP;
            else if (evict_valid_i && valid_q[ptr_q] && dirty_q[ptr_q])
               state_d = S_WB;
            else
               state_d = S_FILL;
         end
         S_SWAP: begin
            vc_idx_o       = hit_idx_q;
            refill_valid_o = 1'b1;
            refill_data_o  = vc_rdata_i;
            refill_dirty_o = dirty_q[hit_idx_q];
            if (evict_valid_i) begin
               vc_we_o    = 1'b1;
               vc_wdata_o = evict_data_i;
            end
            state_d = S_DONE;
         end
         S_WB: begin
            vc_idx_o      = ptr_q;
            mem_wr_req_o  = 1'b1;
            mem_wr_tag_o  = tag_q[ptr_q];
            mem_wr_data_o = vc_rdata_i;
            if (mem_wr_ack_i) state_d = S_FILL;
         end
         S_FILL: begin
            vc_idx_o     = ptr_q;
            mem_rd_req_o = 1'b1;
            mem_rd_tag_o = miss_tag_i;
            if (mem_rd_valid_i) begin
               refill_valid_o = 1'b1;
               refill_data_o  = mem_rd_data_i;
               if (evict_valid_i) begin
                  vc_we_o    = 1'b1;
                  vc_wdata_o = evict_data_i;
               end
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            miss_done_o = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Victim metadata and FIFO pointer updates that follow the sequence.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q   <= '0;
         dirty_q   <= '0;
         ptr_q     <= '0;
         hit_idx_q <= '0;
         for (int i = 0; i < VC_ENTRIES; i++) tag_q[i] <= '0;
      end else begin
         case (state_q)
            S_PROBE: begin
               if (hit_any) hit_idx_q <= hit_idx;
            end
            S_SWAP: begin
               // Swap keeps the entry alive with the L1's line, or frees it.
               if (evict_valid_i) begin
                  tag_q[hit_idx_q]   <= evict_tag_i;
                  dirty_q[hit_idx_q] <= evict_dirty_i;
               end else begin
                  valid_q[hit_idx_q] <= 1'b0;
                  dirty_q[hit_idx_q] <= 1'b0;
               end
            end
            S_WB: begin
               if (mem_wr_ack_i) dirty_q[ptr_q] <= 1'b0;
            end
            S_FILL: begin
               if (mem_rd_valid_i && evict_valid_i) begin
                  valid_q[ptr_q] <= 1'b1;
                  dirty_q[ptr_q] <= evict_dirty_i;
                  tag_q[ptr_q]   <= evict_tag_i;
                  ptr_q          <= ptr_q + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef VICTIM_CACHE_PERF_EN
   logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

   // Saturating event counters for probe hits, probe misses and write-backs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         wb_cnt_q   <= '0;
      end else begin
         if (state_q == S_PROBE && hit_any && hit_cnt_q != 32'hFFFF_FFFF)
            hit_cnt_q <= hit_cnt_q + 32'd1;
         if (state_q == S_PROBE && !hit_any && miss_cnt_q != 32'hFFFF_FFFF)
            miss_cnt_q <= miss_cnt_q + 32'd1;
         if (state_q == S_WB && mem_wr_ack_i && wb_cnt_q != 32'hFFFF_FFFF)
            wb_cnt_q <= wb_cnt_q + 32'd1;
      end
   end

   assign perf_hit_cnt_o  = hit_cnt_q;
   assign perf_miss_cnt_o = miss_cnt_q;
   assign perf_wb_cnt_o   = wb_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_victim_cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_victim_cache_ctrl
//  Purpose  : Self-checking bench for victim_cache_ctrl. Holds a
//             transaction-level model of the victim entries and an external
//             victim data array. Also answers the memory handshakes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_victim_cache_ctrl;

   localparam int LW = 128;
   localparam int TW = 26;
   localparam int N  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          miss_req = 1'b0;
   logic [TW-1:0] miss_tag = '0;
   logic          evict_valid = 1'b0;
   logic          evict_dirty = 1'b0;
   logic [TW-1:0] evict_tag = '0;
   logic [LW-1:0] evict_data = '0;
   logic          refill_valid_o;
   logic [LW-1:0] refill_data_o;
   logic          refill_dirty_o;
   logic          miss_done_o;
   logic [1:0]    vc_idx_o;
   logic          vc_we_o;
   logic [LW-1:0] vc_wdata_o;
   logic [LW-1:0] vc_rdata;
   logic          mem_wr_req_o;
   logic [TW-1:0] mem_wr_tag_o;
   logic [LW-1:0] mem_wr_data_o;
   logic          mem_wr_ack = 1'b0;
   logic          mem_rd_req_o;
   logic [TW-1:0] mem_rd_tag_o;
   logic          mem_rd_valid = 1'b0;
   logic [LW-1:0] mem_rd_data = '0;
`ifdef VICTIM_CACHE_PERF_EN
   logic [31:0]   perf_hit, perf_miss, perf_wb;
`endif

   always #5 clk = ~clk;

   victim_cache_ctrl #(.LINE_WIDTH(LW), .TAG_WIDTH(TW), .VC_ENTRIES(N)) dut (
      .clk(clk), .rst(rst),
      .miss_req_i(miss_req), .miss_tag_i(miss_tag),
      .evict_valid_i(evict_valid), .evict_dirty_i(evict_dirty),
      .evict_tag_i(evict_tag), .evict_data_i(evict_data),
      .refill_valid_o(refill_valid_o), .refill_data_o(refill_data_o),
      .refill_dirty_o(refill_dirty_o), .miss_done_o(miss_done_o),
      .vc_idx_o(vc_idx_o), .vc_we_o(vc_we_o), .vc_wdata_o(vc_wdata_o),
      .vc_rdata_i(vc_rdata),
      .mem_wr_req_o(mem_wr_req_o), .mem_wr_tag_o(mem_wr_tag_o),
      .mem_wr_data_o(mem_wr_data_o), .mem_wr_ack_i(mem_wr_ack),
      .mem_rd_req_o(mem_rd_req_o), .mem_rd_tag_o(mem_rd_tag_o),
      .mem_rd_valid_i(mem_rd_valid), .mem_rd_data_i(mem_rd_data)
`ifdef VICTIM_CACHE_PERF_EN
     ,.perf_hit_cnt_o(perf_hit), .perf_miss_cnt_o(perf_miss), .perf_wb_cnt_o(perf_wb)
`endif
   );

   // External victim data array: combinational read, clocked write.
   logic [LW-1:0] vc_mem [N];
   assign vc_rdata = vc_mem[vc_idx_o];
   always @(posedge clk) if (vc_we_o) vc_mem[vc_idx_o] <= vc_wdata_o;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [LW-1:0] line_of(input logic [TW-1:0] t);
      logic [31:0] w;
      w = 32'(t);
      return {32'hC0DE_0000 ^ w, w, ~w, w * 32'd7};
   endfunction

   // Model of the victim entries.
   bit            m_valid [N];
   bit            m_dirty [N];
   logic [TW-1:0] m_tag   [N];
   logic [LW-1:0] m_data  [N];
   int            m_ptr, m_hits, m_miss, m_wbs;

   // Expectations for the transaction in flight.
   bit            active = 1'b0;
   bit            exp_hit, exp_we, exp_wb, exp_refill_dirty;
   int            exp_idx;
   logic [LW-1:0] exp_refill_data, exp_wdata, exp_wb_data;
   logic [TW-1:0] exp_wb_tag, exp_rd_tag;

   // Observations.
   int            n_refill, n_we, n_done, n_wr, n_rd;
   logic [LW-1:0] last_refill_data;
   logic          last_refill_dirty;
   logic [TW-1:0] last_wr_tag;
   int            last_we_idx;

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0; m_data[i] = '0;
      end
      m_ptr = 0; m_hits = 0; m_miss = 0; m_wbs = 0;
   endtask

   // Compare process: checks every output that carries meaning this cycle.
   always @(negedge clk) begin
      if (rst && active) begin
         if (vc_we_o) begin
            n_we++;
            last_we_idx = int'(vc_idx_o);
            chk("we_allowed", 1'b1, exp_we);
            chk("we_idx", vc_idx_o, exp_idx);
            chk("we_data", vc_wdata_o, exp_wdata);
         end
         if (refill_valid_o) begin
            n_refill++;
            last_refill_data  = refill_data_o;
            last_refill_dirty = refill_dirty_o;
            chk("refill_data", refill_data_o, exp_refill_data);
            chk("refill_dirty", refill_dirty_o, exp_refill_dirty);
         end
         if (mem_wr_req_o) begin
            n_wr++;
            last_wr_tag = mem_wr_tag_o;
            chk("wb_allowed", 1'b1, exp_wb);
            chk("wb_tag", mem_wr_tag_o, exp_wb_tag);
            chk("wb_data", mem_wr_data_o, exp_wb_data);
         end
         if (mem_rd_req_o) begin
            n_rd++;
            chk("rd_allowed", 1'b1, !exp_hit);
            chk("rd_tag", mem_rd_tag_o, exp_rd_tag);
         end
         if (miss_done_o) n_done++;
      end else if (rst && !active) begin
         chk("idle_quiet", {refill_valid_o, miss_done_o, vc_we_o, mem_wr_req_o, mem_rd_req_o}, '0);
      end
   end

   task automatic do_miss(input logic [TW-1:0] tag, input bit evv, input bit evd,
                          input logic [TW-1:0] evt, input int wb_dly, input int rd_dly,
                          input logic [LW-1:0] fill, output int lat);
      int h, t, cyc, wbc, rdc;
      bit fin;
      h = -1;
      for (int i = N - 1; i >= 0; i--) if (m_valid[i] && m_tag[i] == tag) h = i;
      exp_hit = (h >= 0); exp_we = evv; exp_wdata = line_of(evt); exp_rd_tag = tag;
      exp_wb = 0; exp_wb_tag = '0; exp_wb_data = '0;
      if (exp_hit) begin
         m_hits++;
         exp_idx = h; exp_refill_data = m_data[h]; exp_refill_dirty = m_dirty[h];
         if (evv) begin
            m_tag[h] = evt; m_dirty[h] = evd; m_data[h] = line_of(evt);
         end else begin
            m_valid[h] = 0; m_dirty[h] = 0;
         end
      end else begin
         m_miss++;
         t = m_ptr;
         exp_idx = t; exp_refill_data = fill; exp_refill_dirty = 0;
         exp_wb = evv && m_valid[t] && m_dirty[t];
         if (exp_wb) begin
            m_wbs++; exp_wb_tag = m_tag[t]; exp_wb_data = m_data[t];
         end
         if (evv) begin
            m_valid[t] = 1; m_dirty[t] = evd; m_tag[t] = evt; m_data[t] = line_of(evt);
            m_ptr = (m_ptr + 1) % N;
         end
      end
      n_refill = 0; n_we = 0; n_done = 0; n_wr = 0; n_rd = 0;
      active = 1;
      @(posedge clk); #1;
      miss_req = 1; miss_tag = tag; evict_valid = evv; evict_dirty = evd;
      evict_tag = evt; evict_data = line_of(evt);
      cyc = 0; wbc = 0; rdc = 0; fin = 0; lat = 0;
      while (!fin && cyc < 200) begin
         @(posedge clk); #1; cyc++;
         mem_wr_ack = 0; mem_rd_valid = 0; mem_rd_data = '0;
         if (mem_wr_req_o) begin
            if (wbc == wb_dly) mem_wr_ack = 1;
            wbc++;
         end
         if (mem_rd_req_o) begin
            if (rdc == rd_dly) begin mem_rd_valid = 1; mem_rd_data = fill; end
            rdc++;
         end
         if (miss_done_o) begin fin = 1; lat = cyc; end
      end
      if (!fin) chk("miss_timeout", 1'b0, 1'b1);
      @(negedge clk);
      miss_req = 0; evict_valid = 0;
      @(posedge clk); #1;
      active = 0;
      chk("done_count", n_done, 1);
      chk("refill_count", n_refill, 1);
      chk("we_count", n_we, evv ? 1 : 0);
      chk("wb_seen", n_wr > 0, exp_wb);
      if (exp_wb) chk("wb_hold_cycles", n_wr, wb_dly + 1);
      chk("rd_seen", n_rd > 0, !exp_hit);
      if (!exp_hit) chk("rd_hold_cycles", n_rd, rd_dly + 1);
      if (exp_hit) chk("hit_latency", lat, 3);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat, cyc;
      for (int i = 0; i < N; i++) vc_mem[i] = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ctrl", {refill_valid_o, miss_done_o, vc_we_o, mem_wr_req_o, mem_rd_req_o}, '0);
      chk("reset_idx", vc_idx_o, 0);
      rst = 1;

      // Cold miss without a displaced line: plain fill, no array write.
      do_miss(26'h10, 0, 0, 26'h0, 0, 2, 128'hF00D_0010_0000_0000_0000_0000_1234_5678, lat);
      chk("t1_refill_lit", last_refill_data, 128'hF00D_0010_0000_0000_0000_0000_1234_5678);
      chk("t1_no_we", n_we, 0);

      // Five clean evictions: pointer walks 0..3 and wraps back onto entry 0.
      for (int k = 1; k <= 5; k++)
         do_miss(TW'(k), 1, 0, TW'(8'hA0 + k), 0, k % 3, {96'h0, 32'(k) | 32'hFE00_0000}, lat);
      chk("wrap_last_idx", last_we_idx, 0);

      // Hit on 0xA2 sitting in entry 1: swap with a dirty displaced line 0xB0.
      do_miss(26'hA2, 1, 1, 26'hB0, 0, 0, '0, lat);
      chk("swap_idx_lit", last_we_idx, 1);
      chk("swap_data_lit", last_refill_data, line_of(26'hA2));
      chk("swap_lat_lit", lat, 3);

      // Pointer is at entry 1, now dirty 0xB0: write-back with a 3-cycle ack delay.
      do_miss(26'h123, 1, 1, 26'hC0, 3, 1, {96'h0, 32'h0000_0123}, lat);
      chk("wb_tag_lit", last_wr_tag, 26'hB0);
      chk("wb_cycles_lit", n_wr, 4);

      // Hit on dirty 0xC0 with nothing to swap in: dirty refill, entry freed.
      do_miss(26'hC0, 0, 0, 26'h0, 0, 0, '0, lat);
      chk("dirty_hit_lit", last_refill_dirty, 1'b1);

      // Freed entry must no longer hit.
      do_miss(26'hC0, 1, 0, 26'hD0, 0, 0, {96'h0, 32'h0000_00C0}, lat);
      chk("freed_miss_lit", n_rd, 1);

`ifdef VICTIM_CACHE_PERF_EN
      chk("perf_hit", perf_hit, 32'(m_hits));
      chk("perf_miss", perf_miss, 32'(m_miss));
      chk("perf_wb", perf_wb, 32'(m_wbs));
`endif

      // Reset while waiting for fill data aborts the sequence.
      active = 1; exp_hit = 0; exp_rd_tag = 26'h77; exp_wb = 0; exp_we = 0;
      @(posedge clk); #1;
      miss_req = 1; miss_tag = 26'h77; evict_valid = 0;
      cyc = 0;
      while (!mem_rd_req_o && cyc < 20) begin @(posedge clk); #1; cyc++; end
      chk("rst_reach_fill", mem_rd_req_o, 1'b1);
      @(posedge clk); #3;
      rst = 0;
      #1;
      chk("rst_ctrl_zero", {refill_valid_o, refill_dirty_o, miss_done_o, vc_we_o,
                            mem_wr_req_o, mem_rd_req_o}, '0);
      chk("rst_idx_zero", vc_idx_o, 0);
      chk("rst_data_zero", refill_data_o | vc_wdata_o | mem_wr_data_o, '0);
      chk("rst_tag_zero", {mem_wr_tag_o, mem_rd_tag_o}, '0);
`ifdef VICTIM_CACHE_PERF_EN
      chk("rst_perf_zero", {perf_hit, perf_miss, perf_wb}, '0);
`endif
      miss_req = 0;
      active = 0;
      model_reset();
      @(posedge clk); #1;
      rst = 1;

      // 0xA4 was held in entry 3 before reset; it must now miss.
      do_miss(26'hA4, 1, 0, 26'hE0, 0, 1, {96'h0, 32'h0000_00A4}, lat);
      chk("post_rst_miss_lit", n_rd, 2);
      chk("post_rst_idx_lit", last_we_idx, 0);
      do_miss(26'hE0, 0, 0, 26'h0, 0, 0, '0, lat);
      chk("post_rst_hit_lit", last_refill_data, line_of(26'hE0));

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
